// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush-to-bubble and a saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_main_valid_nx;
  logic [DATA_W-1:0] w_main_data_nx;
  logic [CTRL_W-1:0] w_main_ctrl_nx;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_main_valid && out_ready;

  // ctrl register is zeroed whenever the entry empties, so out_ctrl needs no gating
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign stall_cnt = r_stall_cnt;

`ifdef PIPE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;

  logic              w_skid_valid_nx;
  logic [DATA_W-1:0] w_skid_data_nx;
  logic [CTRL_W-1:0] w_skid_ctrl_nx;

  assign in_ready  = r_in_ready && !flush;
  assign occupancy = 2'(r_main_valid) + 2'(r_skid_valid);

  always_comb begin
    w_main_valid_nx = r_main_valid;
    w_main_data_nx  = r_main_data;
    w_main_ctrl_nx  = r_main_ctrl;
    w_skid_valid_nx = r_skid_valid;
    w_skid_data_nx  = r_skid_data;
    w_skid_ctrl_nx  = r_skid_ctrl;
    if (flush) begin
      w_main_valid_nx = 1'b0;
      w_main_ctrl_nx  = '0;
      w_skid_valid_nx = 1'b0;
      w_skid_ctrl_nx  = '0;
    end else if (!r_main_valid || w_out_xfer) begin
      // main is free this edge: refill from skid first to keep ordering
      if (r_skid_valid) begin
        w_main_valid_nx = 1'b1;
        w_main_data_nx  = r_skid_data;
        w_main_ctrl_nx  = r_skid_ctrl;
        if (w_in_xfer) begin
          w_skid_data_nx = in_data;
          w_skid_ctrl_nx = in_ctrl;
        end else begin
          w_skid_valid_nx = 1'b0;
          w_skid_ctrl_nx  = '0;
        end
      end else if (w_in_xfer) begin
        w_main_valid_nx = 1'b1;
        w_main_data_nx  = in_data;
        w_main_ctrl_nx  = in_ctrl;
      end else begin
        w_main_valid_nx = 1'b0;
        w_main_ctrl_nx  = '0;
      end
    end else if (w_in_xfer) begin
      w_skid_valid_nx = 1'b1;
      w_skid_data_nx  = in_data;
      w_skid_ctrl_nx  = in_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_skid_valid <= w_skid_valid_nx;
      r_skid_data  <= w_skid_data_nx;
      r_skid_ctrl  <= w_skid_ctrl_nx;
      r_in_ready   <= !w_skid_valid_nx;
    end
  end
`else
  assign in_ready  = !flush && (!r_main_valid || out_ready);
  assign occupancy = {1'b0, r_main_valid};

  // a new beat replaces a departing one on the same edge
  always_comb begin
    w_main_valid_nx = r_main_valid;
    w_main_data_nx  = r_main_data;
    w_main_ctrl_nx  = r_main_ctrl;
    if (flush) begin
      w_main_valid_nx = 1'b0;
      w_main_ctrl_nx  = '0;
    end else if (w_in_xfer) begin
      w_main_valid_nx = 1'b1;
      w_main_data_nx  = in_data;
      w_main_ctrl_nx  = in_ctrl;
    end else if (w_out_xfer) begin
      w_main_valid_nx = 1'b0;
      w_main_ctrl_nx  = '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
    end else begin
      r_main_valid <= w_main_valid_nx;
      r_main_data  <= w_main_data_nx;
      r_main_ctrl  <= w_main_ctrl_nx;
    end
  end

  // stall counter is cleared only by reset and saturates at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (CNT_W=4); expectations follow PIPE_SKID_EN when defined.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 4;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_occ",   64'(occupancy), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // streaming 0x100..0x104
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = DATA_W'(32'h100 + i);
      in_ctrl = CTRL_W'(i + 1);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data",  64'(out_data),  64'(32'h100 + i));
      check("stream_ctrl",  64'(out_ctrl),  64'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 64'(out_valid), 64'd0);
    check("stream_end_ctrl",  64'(out_ctrl),  64'd0);
    check("stream_stall",     64'(stall_cnt), 64'd0);

    // stall with 0xA5 held
    in_valid = 1'b1; in_data = 32'hA5; in_ctrl = 8'h3C;
    tick();
    out_ready = 1'b0; in_data = 32'hB6; in_ctrl = 8'h11;
    #1;
    check("stall_first_in_ready", 64'(in_ready), SKID ? 64'd1 : 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_data", 64'(out_data), 64'hA5);
    end
    check("stall_ctrl",     64'(out_ctrl),  64'h3C);
    check("stall_cnt3",     64'(stall_cnt), 64'd3);
    check("stall_occ",      64'(occupancy), SKID ? 64'd2 : 64'd1);
    check("stall_in_ready", 64'(in_ready),  64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("unstall_valid", 64'(out_valid), SKID ? 64'd1 : 64'd0);
    check("unstall_data",  64'(out_data),  SKID ? 64'hB6 : 64'hA5);
    tick();
    check("unstall_empty", 64'(out_valid), 64'd0);
    check("unstall_stall", 64'(stall_cnt), 64'd3);

    // back-to-back 0x1 then 0x2 under stall, then release
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1; in_ctrl = 8'h01;
    tick();
    in_data = 32'h2; in_ctrl = 8'h02;
    tick();
    check("drain_occ_full", 64'(occupancy), SKID ? 64'd2 : 64'd1);
    check("drain_first",    64'(out_data),  64'h1);
    out_ready = 1'b1; in_valid = !SKID;
    tick();
    check("drain_second_valid", 64'(out_valid), 64'd1);
    check("drain_second_data",  64'(out_data),  64'h2);
    check("drain_second_ctrl",  64'(out_ctrl),  64'h02);
    check("drain_occ1",         64'(occupancy), 64'd1);
    in_valid = 1'b0;
    tick();
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_occ0",  64'(occupancy), 64'd0);
    check("drain_stall", 64'(stall_cnt), 64'd4);

    // flush with a colliding incoming beat
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234; in_ctrl = 8'hFF;
    tick();
    check("preflush_ctrl", 64'(out_ctrl), 64'hFF);
    check("preflush_data", 64'(out_data), 64'h1234);
    flush = 1'b1; in_data = 32'h5678; in_ctrl = 8'h77;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl",  64'(out_ctrl),  64'd0);
    check("flush_occ",   64'(occupancy), 64'd0);
    check("flush_data",  64'(out_data),  64'h1234);
    check("flush_stall", 64'(stall_cnt), 64'd5);
    out_ready = 1'b1;
    tick();
    check("postflush_valid", 64'(out_valid), 64'd0);
    check("postflush_data",  64'(out_data),  64'h1234);

    // saturation of the 4-bit stall counter
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hCAFE; in_ctrl = 8'h05;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("sat_cnt",  64'(stall_cnt), 64'd15);
    check("sat_data", 64'(out_data),  64'hCAFE);
    repeat (2) tick();
    check("sat_hold", 64'(stall_cnt), 64'd15);

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", 64'(out_valid), 64'd0);
    check("areset_ctrl",  64'(out_ctrl),  64'd0);
    check("areset_occ",   64'(occupancy), 64'd0);
    check("areset_stall", 64'(stall_cnt), 64'd0);
    check("areset_data",  64'(out_data),  64'd0);
    reset = 1'b0;
    #1;
    check("areset_in_ready", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries an opaque data payload and a separately flushable control field between two stages using valid/ready flow control. It supports stall back-pressure, flush-to-bubble, a saturating stall-cycle counter and an optional skid entry. Every inter-stage boundary of the processor pipeline instantiates one copy.

## Interface
- DATA_W, 32: payload width (PC, PC+4, ALU result, read data, register index, ...); kept on flush.
- CTRL_W, 8: control-field width (RegWrite, MemRead, MemtoReg, ...); forced to zero on reset and flush.
- CNT_W, 16: width of the stall counter.

- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high.
- flush  input  1  synchronous kill of every held entry.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control.
- out_valid  output  1  held beat presented downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  presented payload.
- out_ctrl  output  CTRL_W  presented control; zero whenever out_valid=0.
- occupancy  output  2  number of held entries (0..2).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Main entry: holds {valid, data, ctrl}. It drives out_* directly, so out_* are registered outputs.
- out_ctrl is gated: it equals the main ctrl when valid and is zero otherwise. Consumers never see stale control.
- Flush has priority over everything. On the next edge all valid bits clear, ctrl registers go to 0, data registers keep their values, and an incoming beat in the same cycle is discarded.
- in_ready is forced to 0 while flush=1.
- Simultaneous in and out transfers with a single-entry design: the new beat replaces the departing beat, giving full throughput with no bubble.
- stall_cnt increments each cycle with out_valid=1 and out_ready=0. It saturates at 2^CNT_W-1. It is cleared only by reset; flush does not clear it.
- occupancy equals 0 or 1 without skid, and 0, 1 or 2 with skid.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0. in_ready is 1 while reset is deasserted and the stage is empty.
- Latency is 1 cycle from in transfer to out_valid, with no skid path involved.
- Reset asserted mid-transfer discards all entries immediately and asynchronously.
- out_valid never drops without an out transfer or a flush. out_data and out_ctrl are stable while out_valid=1 and out_ready=0.

## Configuration
- PIPE_SKID_EN defined:
  - Adds a second (skid) entry, and in_ready is a registered signal equal to !skid_valid.
  - A beat accepted while main is valid and out_ready=0 goes to skid.
  - On an out transfer with skid valid, skid moves to main on that edge. If in_valid arrives on that same edge, the new beat is written to skid, and only if skid is being vacated.
  - in_ready has no combinational path from out_ready.
  - A flush clears both entries.
- PIPE_SKID_EN undefined:
  - Single entry, occupancy max 1.
  - in_ready = !flush && (!out_valid || out_ready), which is a combinational path from out_ready.

## Test plan
- Streaming: in_valid=1 with data 0x100..0x104 and out_ready=1 -> out_data 0x100..0x104 on consecutive cycles, each 1 cycle late; stall_cnt=0.
- Stall: hold out_ready=0 for 3 cycles with data 0xA5 held -> out_data=0xA5 stays stable and stall_cnt=3. Without skid, in_ready=0; with skid, one extra beat is accepted, occupancy=2, then in_ready=0.
- Flush: with ctrl=0xFF and data=0x1234 valid, assert flush together with in_valid (data 0x5678) -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0, and 0x5678 never appears.
- Skid drain (PIPE_SKID_EN): occupancy=2 holding 0x1 then 0x2, release out_ready -> 0x1 then 0x2 on consecutive cycles with no loss or reordering.
- Saturation: with CNT_W=4, stall for 20 cycles -> stall_cnt=15 and holding.
- Async reset mid-stall: assert reset between edges -> out_valid, out_ctrl, occupancy and stall_cnt go to 0 immediately, without waiting for a clock edge.
